m6502_mem_bridge: RTL and testbench

//  Bus bridge directly downstream of the m6502 CPU bus port (addr/rd_req/wr_en/wr_data -> rd_data/ready).

---
 rtl/m6502_mem_bridge_if.sv | 45 ++++
 rtl/m6502_mem_bridge.sv | 185 ++++++++++++++++++
 tb/tb_m6502_mem_bridge.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/m6502_mem_bridge_if.sv
// m6502_mem_bridge_if
//  Bus bundle between the m6502 CPU port, the video/DMA master, the memory
//  port and m6502_mem_bridge.
//  slave  : the bridge's view (takes CPU/DMA requests and memory responses,
//           drives CPU/DMA results and memory strobes).
//  master : the surrounding system's view (CPU, DMA master and memory).
//  CPU : cpu_addr, cpu_rd_req, cpu_wr_en, cpu_wr_data -> cpu_rd_data, cpu_ready
//  DMA : dma_req, dma_addr -> dma_rd_data, dma_ack
//  MEM : mem_addr, mem_rd, mem_wr, mem_wdata <- mem_rdata, mem_ack
interface m6502_mem_bridge_if;
  logic [15:0] cpu_addr;
  logic        cpu_rd_req;
  logic        cpu_wr_en;
  logic [7:0]  cpu_wr_data;
  logic [7:0]  cpu_rd_data;
  logic        cpu_ready;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic [7:0]  dma_rd_data;
  logic        dma_ack;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport slave (
    input  cpu_addr, cpu_rd_req, cpu_wr_en, cpu_wr_data,
    input  dma_req, dma_addr,
    input  mem_rdata, mem_ack,
    output cpu_rd_data, cpu_ready,
    output dma_rd_data, dma_ack,
    output mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output cpu_addr, cpu_rd_req, cpu_wr_en, cpu_wr_data,
    output dma_req, dma_addr,
    output mem_rdata, mem_ack,
    input  cpu_rd_data, cpu_ready,
    input  dma_rd_data, dma_ack,
    input  mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/m6502_mem_bridge.sv
// m6502_mem_bridge
//  Bridge between the m6502 CPU bus port and a variable-latency memory port.
//  Single-cycle CPU read/write pulses are latched and arbitrated round robin
//  against a DMA read master; one memory access is in flight at a time and
//  each is completed by mem_ack or by a TIMEOUT-cycle watchdog (data 8'hFF).
//  Ports:
//   clk      : system clock, posedge
//   reset_n  : synchronous active-low reset
//   bus      : m6502_mem_bridge_if.slave (CPU, DMA and memory signals)
//  Parameters:
//   TIMEOUT      : WAIT cycles before a missing mem_ack is forced (2..31)
//   RESET_VECTOR : value returned for $FFFC/$FFFD when the vector feature is on
//  Build option:
//   M6502_BRIDGE_RESET_VEC_EN : CPU reads of $FFFC/$FFFD are answered from
//   RESET_VECTOR in IDLE without touching memory.
module m6502_mem_bridge #(
  parameter int unsigned TIMEOUT      = 16,
  parameter logic [15:0] RESET_VECTOR = 16'hE000
) (
  input  logic              clk,
  input  logic              reset_n,
  m6502_mem_bridge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [4:0] TMO_LIMIT = 5'(TIMEOUT);

  state_t      state, state_nxt;

  logic        cpu_pend;
  logic        cpu_wr_q;
  logic [15:0] cpu_addr_q;
  logic [7:0]  cpu_wdata_q;
  logic        prio_dma;   // DMA wins the next contended arbitration
  logic        owner_dma;  // master of the access in flight
  logic [4:0]  tmo_cnt;
  logic [4:0]  tmo_cnt_inc;

  logic        cpu_new;
  logic        cpu_wr_eff;
  logic [15:0] cpu_addr_eff;
  logic [7:0]  cpu_wdata_eff;
  logic        is_vec_eff;
  logic        cpu_vec_done;
  logic [7:0]  vec_byte;
  logic        cpu_mem_req;
  logic        dma_mem_req;
  logic        grant_cpu;
  logic        grant_dma;
  logic        done;
  logic        timed_out;
  logic [7:0]  done_data;

  // A pulse arriving while a request is pending is dropped.
  assign cpu_new = (bus.cpu_rd_req | bus.cpu_wr_en) & ~cpu_pend;

  // The arbiter sees a fresh pulse in its capture cycle so that the memory
  // strobe follows the request by one cycle; afterwards the latched copy is used.
  assign cpu_wr_eff    = cpu_pend ? cpu_wr_q    : bus.cpu_wr_en;
  assign cpu_addr_eff  = cpu_pend ? cpu_addr_q  : bus.cpu_addr;
  assign cpu_wdata_eff = cpu_pend ? cpu_wdata_q : bus.cpu_wr_data;

`ifdef M6502_BRIDGE_RESET_VEC_EN
  assign is_vec_eff = ~cpu_wr_eff & (cpu_addr_eff[15:1] == 15'h7FFE);
`else
  assign is_vec_eff = 1'b0;
`endif

  assign vec_byte     = cpu_addr_eff[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
  assign cpu_vec_done = (state == IDLE) & cpu_pend & is_vec_eff;
  assign cpu_mem_req  = (cpu_pend | cpu_new) & ~is_vec_eff;
  // The request is still high in the ack cycle; masking it avoids a re-grant.
  assign dma_mem_req  = bus.dma_req & ~bus.dma_ack;

  assign tmo_cnt_inc = (tmo_cnt == 5'h1F) ? tmo_cnt : tmo_cnt + 5'd1;
  assign done_data   = timed_out ? 8'hFF : bus.mem_rdata;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_mem_req && dma_mem_req) begin
          grant_dma = prio_dma;
          grant_cpu = ~prio_dma;
          state_nxt = ISSUE;
        end else if (cpu_mem_req) begin
          grant_cpu = 1'b1;
          state_nxt = ISSUE;
        end else if (dma_mem_req) begin
          grant_dma = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.mem_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_cnt_inc == TMO_LIMIT) begin
          done      = 1'b1;
          timed_out = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_pend        <= 1'b0;
      cpu_wr_q        <= 1'b0;
      cpu_addr_q      <= '0;
      cpu_wdata_q     <= '0;
      prio_dma        <= 1'b0;
      owner_dma       <= 1'b0;
      tmo_cnt         <= '0;
      bus.cpu_ready   <= 1'b1;
      bus.cpu_rd_data <= '0;
      bus.dma_rd_data <= '0;
      bus.dma_ack     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.mem_rd      <= 1'b0;
      bus.mem_wr      <= 1'b0;
    end else begin
      bus.dma_ack <= 1'b0;

      if (cpu_new) begin
        cpu_pend      <= 1'b1;
        cpu_wr_q      <= bus.cpu_wr_en;
        cpu_addr_q    <= bus.cpu_addr;
        cpu_wdata_q   <= bus.cpu_wr_data;
        bus.cpu_ready <= 1'b0;
      end

      if (grant_cpu || grant_dma) begin
        owner_dma    <= grant_dma;
        bus.mem_addr <= grant_dma ? bus.dma_addr : cpu_addr_eff;
        bus.mem_rd   <= grant_dma | ~cpu_wr_eff;
        bus.mem_wr   <= grant_cpu & cpu_wr_eff;
        tmo_cnt      <= '0;
        if (grant_cpu) bus.mem_wdata <= cpu_wdata_eff;
        // Priority moves only when both masters competed: the loser of a
        // contended grant wins the next one.
        if (cpu_mem_req && dma_mem_req) prio_dma <= grant_cpu;
      end

      if (state == ISSUE) begin
        bus.mem_rd <= 1'b0;
        bus.mem_wr <= 1'b0;
      end

      if (state == WAIT) tmo_cnt <= tmo_cnt_inc;

      if (done) begin
        if (owner_dma) begin
          bus.dma_rd_data <= done_data;
          bus.dma_ack     <= 1'b1;
        end else begin
          if (!cpu_wr_q) bus.cpu_rd_data <= done_data;
          bus.cpu_ready <= 1'b1;
          cpu_pend      <= 1'b0;
        end
      end

      if (cpu_vec_done) begin
        bus.cpu_rd_data <= vec_byte;
        bus.cpu_ready   <= 1'b1;
        cpu_pend        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_m6502_mem_bridge.sv
module tb_m6502_mem_bridge;

  logic clk;
  logic reset_n;

  m6502_mem_bridge_if bus ();

  m6502_mem_bridge #(
    .TIMEOUT      (16),
    .RESET_VECTOR (16'hE000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory responder settings
  int          resp_lat  = 1;     // cycles from strobe to mem_ack
  logic [7:0]  resp_data = 8'h00;

  // strobe monitor
  int          rd_cnt  = 0;
  int          wr_cnt  = 0;
  int          overlap = 0;
  logic [15:0] last_addr  = '0;
  logic [7:0]  last_wdata = '0;
  logic [15:0] addr_q[$];

  typedef struct {
    logic        wr;
    logic        both;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          lat;
    logic [7:0]  rdata;
    logic [7:0]  exp_rd;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cpu_pulse(input logic wr, input logic both, input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr    = a;
    bus.cpu_wr_data = d;
    bus.cpu_wr_en   = wr;
    bus.cpu_rd_req  = ~wr | both;
    step();
    bus.cpu_wr_en  = 1'b0;
    bus.cpu_rd_req = 1'b0;
  endtask

  // n = cycles from the request cycle to the first cycle with cpu_ready=1
  task automatic wait_ready(output int n);
    n = 1;
    while (!bus.cpu_ready && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic wait_dma(output int n);
    n = 1;
    while (!bus.dma_ack && n < 60) begin
      step();
      n++;
    end
    bus.dma_req = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_rd) rd_cnt++;
      if (bus.mem_wr) wr_cnt++;
      if (bus.mem_rd && bus.mem_wr) overlap++;
      if (bus.mem_rd || bus.mem_wr) begin
        last_addr  = bus.mem_addr;
        last_wdata = bus.mem_wdata;
        addr_q.push_back(bus.mem_addr);
      end
    end
  end

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      step();
      if ((bus.mem_rd || bus.mem_wr) && reset_n) begin
        repeat (resp_lat) @(posedge clk);
        #1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = resp_data;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rd0;
    int wr0;
    string nm;

    vecs[0] = '{1'b0, 1'b0, 16'h1234, 8'h00, 2, 8'hA5, 8'hA5, 4, 1, 0};
    vecs[1] = '{1'b1, 1'b0, 16'h0200, 8'h3C, 1, 8'h00, 8'hA5, 3, 0, 1};
    vecs[2] = '{1'b0, 1'b0, 16'h00FF, 8'h00, 1, 8'h5A, 8'h5A, 3, 1, 0};
    vecs[3] = '{1'b1, 1'b1, 16'h0300, 8'h99, 3, 8'h00, 8'h5A, 5, 0, 1};
`ifdef M6502_BRIDGE_RESET_VEC_EN
    vecs[4] = '{1'b0, 1'b0, 16'hFFFC, 8'h00, 3, 8'h12, 8'h00, 2, 0, 0};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFD, 8'h00, 1, 8'h34, 8'hE0, 2, 0, 0};
    vecs[6] = '{1'b1, 1'b0, 16'hFFFC, 8'h77, 2, 8'h00, 8'hE0, 4, 0, 1};
`else
    vecs[4] = '{1'b0, 1'b0, 16'hFFFC, 8'h00, 3, 8'h12, 8'h12, 5, 1, 0};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFD, 8'h00, 1, 8'h34, 8'h34, 3, 1, 0};
    vecs[6] = '{1'b1, 1'b0, 16'hFFFC, 8'h77, 2, 8'h00, 8'h34, 4, 0, 1};
`endif
    vecs[7] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 1, 8'hC7, 8'hC7, 3, 1, 0};

    reset_n         = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_rd_req  = 1'b0;
    bus.cpu_wr_en   = 1'b0;
    bus.cpu_wr_data = '0;
    bus.dma_req     = 1'b0;
    bus.dma_addr    = '0;
    repeat (3) step();

    check("rst cpu_ready",   32'(bus.cpu_ready),   1);
    check("rst cpu_rd_data", 32'(bus.cpu_rd_data), 0);
    check("rst dma_rd_data", 32'(bus.dma_rd_data), 0);
    check("rst dma_ack",     32'(bus.dma_ack),     0);
    check("rst mem_rd",      32'(bus.mem_rd),      0);
    check("rst mem_wr",      32'(bus.mem_wr),      0);
    check("rst mem_addr",    32'(bus.mem_addr),    0);
    check("rst mem_wdata",   32'(bus.mem_wdata),   0);
    reset_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 8; i++) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      resp_lat  = vecs[i].lat;
      resp_data = vecs[i].rdata;
      cpu_pulse(vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].wdata);
      nm = $sformatf("vec%0d", i);
      check({nm, " ready_low"}, 32'(bus.cpu_ready), 0);
      wait_ready(n);
      check({nm, " latency"}, 32'(n), 32'(vecs[i].exp_lat));
      check({nm, " rd_data"}, 32'(bus.cpu_rd_data), 32'(vecs[i].exp_rd));
      check({nm, " n_mem_rd"}, 32'(rd_cnt - rd0), 32'(vecs[i].exp_nrd));
      check({nm, " n_mem_wr"}, 32'(wr_cnt - wr0), 32'(vecs[i].exp_nwr));
      if (vecs[i].exp_nrd + vecs[i].exp_nwr > 0)
        check({nm, " mem_addr"}, 32'(last_addr), 32'(vecs[i].addr));
      if (vecs[i].exp_nwr > 0)
        check({nm, " mem_wdata"}, 32'(last_wdata), 32'(vecs[i].wdata));
      repeat (2) step();
    end

    // timeout: ack arrives long after the watchdog has fired
    rd0 = rd_cnt;
    resp_lat  = 25;
    resp_data = 8'h3B;
    cpu_pulse(1'b0, 1'b0, 16'h8888, 8'h00);
    wait_ready(n);
    check("tmo latency", 32'(n), 18);
    check("tmo rd_data", 32'(bus.cpu_rd_data), 32'h0FF);
    repeat (12) step();
    check("tmo late ack rd_data", 32'(bus.cpu_rd_data), 32'h0FF);
    check("tmo late ack ready", 32'(bus.cpu_ready), 1);
    check("tmo n_mem_rd", 32'(rd_cnt - rd0), 1);

    // second pulse while the first is pending is dropped
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    resp_lat  = 3;
    resp_data = 8'h4D;
    cpu_pulse(1'b0, 1'b0, 16'h5555, 8'h00);
    cpu_pulse(1'b1, 1'b0, 16'h6666, 8'h11);
    wait_ready(n);
    check("perr ready", 32'(n < 60), 1);
    check("perr rd_data", 32'(bus.cpu_rd_data), 32'h4D);
    check("perr mem_addr", 32'(last_addr), 32'h5555);
    check("perr n_mem_rd", 32'(rd_cnt - rd0), 1);
    check("perr n_mem_wr", 32'(wr_cnt - wr0), 0);
    repeat (2) step();

    // reset while waiting for mem_ack; the ack lands afterwards
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    resp_lat  = 4;
    resp_data = 8'hC3;
    cpu_pulse(1'b0, 1'b0, 16'h7777, 8'h00);
    step();
    reset_n = 1'b0;
    step();
    check("midrst cpu_ready",   32'(bus.cpu_ready),   1);
    check("midrst cpu_rd_data", 32'(bus.cpu_rd_data), 0);
    check("midrst mem_addr",    32'(bus.mem_addr),    0);
    check("midrst mem_wdata",   32'(bus.mem_wdata),   0);
    check("midrst mem_rd",      32'(bus.mem_rd),      0);
    reset_n = 1'b1;
    repeat (6) step();
    check("midrst late ack rd_data", 32'(bus.cpu_rd_data), 0);
    check("midrst late ack ready",   32'(bus.cpu_ready),   1);
    check("midrst n_mem_rd", 32'(rd_cnt - rd0), 1);
    check("midrst n_mem_wr", 32'(wr_cnt - wr0), 0);

    // round robin after reset: CPU first, then on the next contention DMA first
    addr_q.delete();
    resp_lat  = 1;
    resp_data = 8'h6B;
    bus.dma_addr = 16'h2222;
    bus.dma_req  = 1'b1;
    cpu_pulse(1'b0, 1'b0, 16'h1111, 8'h00);
    wait_dma(n);
    check("arb1 dma_ack seen", 32'(n < 60), 1);
    check("arb1 dma_rd_data", 32'(bus.dma_rd_data), 32'h6B);
    check("arb1 cpu_rd_data", 32'(bus.cpu_rd_data), 32'h6B);
    step();
    check("arb1 dma_ack width", 32'(bus.dma_ack), 0);
    repeat (3) step();
    check("arb1 n_access", 32'(addr_q.size()), 2);
    check("arb1 first",  32'(addr_q[0]), 32'h1111);
    check("arb1 second", 32'(addr_q[1]), 32'h2222);

    addr_q.delete();
    resp_data = 8'h9E;
    bus.dma_addr = 16'h4444;
    bus.dma_req  = 1'b1;
    cpu_pulse(1'b0, 1'b0, 16'h3333, 8'h00);
    wait_dma(n);
    check("arb2 dma_ack seen", 32'(n < 60), 1);
    wait_ready(n);
    check("arb2 cpu ready", 32'(n < 60), 1);
    check("arb2 cpu_rd_data", 32'(bus.cpu_rd_data), 32'h9E);
    check("arb2 dma_rd_data", 32'(bus.dma_rd_data), 32'h9E);
    repeat (3) step();
    check("arb2 n_access", 32'(addr_q.size()), 2);
    check("arb2 first",  32'(addr_q[0]), 32'h4444);
    check("arb2 second", 32'(addr_q[1]), 32'h3333);

    check("rd_wr overlap", 32'(overlap), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
